// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv window scheduler and its window counter.
package conv_pkg;

  localparam int unsigned AddrWDefault = 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  function automatic int unsigned result_dim(input int unsigned img, input int unsigned wei,
                                             input int unsigned pad, input int unsigned stride);
    return (img + 2 * pad - wei) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_window_counter.sv
// Nested column/row/channel window counters with linear result address and stride-scaled anchors.
module conv_window_counter
  import conv_pkg::*;
#(
  parameter int unsigned OUTPUT_CHANNEL = 1,
  parameter int unsigned RESULT_WIDTH   = 2,
  parameter int unsigned RESULT_LENGTH  = 2,
  parameter int unsigned STRIDE         = 2,
  parameter int unsigned ADDR_W         = AddrWDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic              last,
  output logic [ADDR_W-1:0] oc_idx,
  output logic [ADDR_W-1:0] anchor_1d,
  output logic [ADDR_W-1:0] anchor_2d,
  output logic [ADDR_W-1:0] lin_addr
);

  logic [ADDR_W-1:0] c_q, c_d, r_q, r_d, oc_q, oc_d, addr_q, addr_d;
  logic              c_last, r_last, oc_last;

  assign c_last  = (c_q == ADDR_W'(RESULT_WIDTH - 1));
  assign r_last  = (r_q == ADDR_W'(RESULT_LENGTH - 1));
  assign oc_last = (oc_q == ADDR_W'(OUTPUT_CHANNEL - 1));
  assign last    = c_last & r_last & oc_last;

  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    oc_d   = oc_q;
    addr_d = addr_q;
    if (clr) begin
      c_d    = '0;
      r_d    = '0;
      oc_d   = '0;
      addr_d = '0;
    end else if (inc && !last) begin
      // Linear address tracks oc*RW*RL + r*RW + c without a multiplier.
      addr_d = addr_q + ADDR_W'(1);
      if (c_last) begin
        c_d = '0;
        if (r_last) begin
          r_d  = '0;
          oc_d = oc_q + ADDR_W'(1);
        end else begin
          r_d = r_q + ADDR_W'(1);
        end
      end else begin
        c_d = c_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q    <= '0;
      r_q    <= '0;
      oc_q   <= '0;
      addr_q <= '0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      oc_q   <= oc_d;
      addr_q <= addr_d;
    end
  end

  assign oc_idx    = oc_q;
  assign lin_addr  = addr_q;
  assign anchor_1d = ADDR_W'(c_q * STRIDE);
  assign anchor_2d = ADDR_W'(r_q * STRIDE);

endmodule

// File: rtl/conv_window_scheduler.sv
// Drives one shared conv unit across every output window of a layer, with CU timeout and abort.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned OUTPUT_CHANNEL = 1,
  parameter int unsigned IMAGE_WIDTH    = 4,
  parameter int unsigned IMAGE_LENGTH   = 4,
  parameter int unsigned WEIGHT_WIDTH   = 2,
  parameter int unsigned WEIGHT_LENGTH  = 2,
  parameter int unsigned STRIDE         = 2,
  parameter int unsigned PADDING        = 0,
  parameter int unsigned ADDR_W         = AddrWDefault,
  parameter int unsigned CU_TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              cu_out_valid,
  output logic              busy,
  output logic              cu_conv_en,
  output logic [ADDR_W-1:0] anchor_1D,
  output logic [ADDR_W-1:0] anchor_2D,
  output logic [ADDR_W-1:0] oc_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done,
  output logic              error
);

  localparam int unsigned RESULT_WIDTH  = result_dim(IMAGE_WIDTH, WEIGHT_WIDTH, PADDING, STRIDE);
  localparam int unsigned RESULT_LENGTH = result_dim(IMAGE_LENGTH, WEIGHT_LENGTH, PADDING, STRIDE);
  localparam int unsigned TmoW          = $clog2(CU_TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            error_q, error_d;
  logic            clr, inc, last;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    clr     = 1'b0;
    inc     = 1'b0;
    // Abort outranks valid and timeout in the same cycle; error is deliberately kept.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      tmo_d   = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StIssue;
            clr     = 1'b1;
            error_d = 1'b0;
          end
        end
        StIssue: begin
          state_d = StWait;
          tmo_d   = '0;
        end
        StWait: begin
          if (cu_out_valid) begin
            state_d = StWrite;
          end else if (tmo_q == TmoW'(CU_TIMEOUT - 1)) begin
            state_d = StIdle;
            error_d = 1'b1;
            tmo_d   = '0;
            clr     = 1'b1;
          end else begin
            tmo_d = tmo_q + TmoW'(1);
          end
        end
        StWrite: begin
          inc     = 1'b1;
          state_d = last ? StDone : StIssue;
        end
        StDone: begin
          state_d = StIdle;
          clr     = 1'b1;
        end
        default: begin
          state_d = StIdle;
          clr     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  conv_window_counter #(
    .OUTPUT_CHANNEL(OUTPUT_CHANNEL),
    .RESULT_WIDTH  (RESULT_WIDTH),
    .RESULT_LENGTH (RESULT_LENGTH),
    .STRIDE        (STRIDE),
    .ADDR_W        (ADDR_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .inc      (inc),
    .last     (last),
    .oc_idx   (oc_idx),
    .anchor_1d(anchor_1D),
    .anchor_2d(anchor_2D),
    .lin_addr (wr_addr)
  );

  assign busy       = (state_q != StIdle);
  assign cu_conv_en = (state_q == StIssue);
  assign wr_en      = (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign error      = error_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench: two scheduler configurations run side by side against an arithmetic window model.
module tb_conv_window_scheduler;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 16;
  localparam int unsigned IMG = 4;

  typedef struct {
    int a1;
    int a2;
    int oc;
    int addr;
  } win_t;

  logic clk = 1'b0;
  logic reset;
  logic start, abort, force_v;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fixed_dly;  // >=0 fixed extra wait cycles, -1 random, -2 conv unit never answers
  bit spur_mode;
  event ev_start, ev_flush;

  logic          busy_s[2], cu_en_s[2], wr_en_s[2], done_s[2], err_s[2];
  logic [AW-1:0] a1_s[2], a2_s[2], oc_s[2], wa_s[2];
  int            wr_cnt[2], done_cnt[2];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Config 0: spec defaults. Config 1: 2 channels, 3x3 kernel, stride 1, padding 1.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned OC = (g == 0) ? 1 : 2;
    localparam int unsigned WK = (g == 0) ? 2 : 3;
    localparam int unsigned S  = (g == 0) ? 2 : 1;
    localparam int unsigned P  = (g == 0) ? 0 : 1;
    localparam int unsigned RD = (IMG - WK + 2 * P) / S + 1;

    win_t iss_q[$];
    win_t wr_q[$];
    int   exp_busy = -1;
    int   bcnt = 0;
    logic cu_v = 1'b0;
    logic spur = 1'b0;

    conv_window_scheduler #(
      .OUTPUT_CHANNEL(OC),
      .IMAGE_WIDTH   (IMG),
      .IMAGE_LENGTH  (IMG),
      .WEIGHT_WIDTH  (WK),
      .WEIGHT_LENGTH (WK),
      .STRIDE        (S),
      .PADDING       (P),
      .ADDR_W        (AW),
      .CU_TIMEOUT    (TMO)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .cu_out_valid(cu_v | spur | force_v),
      .busy        (busy_s[g]),
      .cu_conv_en  (cu_en_s[g]),
      .anchor_1D   (a1_s[g]),
      .anchor_2D   (a2_s[g]),
      .oc_idx      (oc_s[g]),
      .wr_en       (wr_en_s[g]),
      .wr_addr     (wa_s[g]),
      .done        (done_s[g]),
      .error       (err_s[g])
    );

    // Model: expected window order and per-layer busy length.
    initial forever begin
      @(ev_start);
      iss_q.delete();
      wr_q.delete();
      for (int o = 0; o < int'(OC); o++)
        for (int r = 0; r < int'(RD); r++)
          for (int c = 0; c < int'(RD); c++) begin
            win_t w;
            w.a1   = c * int'(S);
            w.a2   = r * int'(S);
            w.oc   = o;
            w.addr = o * int'(RD * RD) + r * int'(RD) + c;
            iss_q.push_back(w);
            wr_q.push_back(w);
          end
      if (fixed_dly == -2) exp_busy = 1 + int'(TMO);
      else if (fixed_dly >= 0) exp_busy = int'(OC * RD * RD) * (3 + fixed_dly) + 1;
      else exp_busy = -1;
    end

    initial forever begin
      @(ev_flush);
      iss_q.delete();
      wr_q.delete();
      exp_busy = -1;
    end

    // Conv unit responder: valid arrives d+1 cycles after the launch cycle.
    initial begin
      int d;
      forever begin
        @(negedge clk);
        if (reset && cu_en_s[g] && fixed_dly != -2) begin
          d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
          @(negedge clk);
          repeat (d) @(negedge clk);
          cu_v = 1'b1;
          @(negedge clk);
          cu_v = 1'b0;
        end
      end
    end

    // Spurious valid during the ISSUE cycle.
    initial forever begin
      @(negedge clk);
      spur = spur_mode && reset && cu_en_s[g];
    end

    // Monitor.
    initial begin
      win_t w;
      forever begin
        @(negedge clk);
        if (!reset) begin
          bcnt = 0;
        end else begin
          if (busy_s[g]) begin
            bcnt++;
          end else if (bcnt > 0) begin
            if (exp_busy >= 0) check($sformatf("d%0d busy_cycles", g), bcnt, exp_busy);
            bcnt = 0;
          end
          if (cu_en_s[g]) begin
            if (iss_q.size() == 0) begin
              check($sformatf("d%0d unexpected_issue", g), 1, 0);
            end else begin
              w = iss_q.pop_front();
              check($sformatf("d%0d issue anchor_1D", g), a1_s[g], w.a1);
              check($sformatf("d%0d issue anchor_2D", g), a2_s[g], w.a2);
              check($sformatf("d%0d issue oc_idx", g), oc_s[g], w.oc);
            end
          end
          if (wr_en_s[g]) begin
            wr_cnt[g]++;
            if (wr_q.size() == 0) begin
              check($sformatf("d%0d unexpected_write", g), 1, 0);
            end else begin
              w = wr_q.pop_front();
              check($sformatf("d%0d wr_addr", g), wa_s[g], w.addr);
              check($sformatf("d%0d write anchors", g), {a2_s[g], a1_s[g]}, {8'(w.a2), 8'(w.a1)});
              check($sformatf("d%0d write oc_idx", g), oc_s[g], w.oc);
            end
          end
          if (done_s[g]) begin
            done_cnt[g]++;
            check($sformatf("d%0d done_with_pending_writes", g), wr_q.size(), 0);
          end
        end
      end
    end
  end

  task automatic check_idle(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s d%0d ctrl", tag, g), {busy_s[g], cu_en_s[g], wr_en_s[g], done_s[g]}, 0);
      check($sformatf("%s d%0d anchors/oc", tag, g), {a1_s[g], a2_s[g], oc_s[g]}, 0);
      check($sformatf("%s d%0d wr_addr", tag, g), wa_s[g], 0);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy_s[0] || busy_s[1]) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_idle bound", {busy_s[0], busy_s[1]}, 0);
  endtask

  task automatic launch(input int dly, input int hold);
    fixed_dly = dly;
    start = 1'b1;
    ->ev_start;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input int dly, input int hold);
    int w0[2], d0[2];
    for (int g = 0; g < 2; g++) begin
      w0[g] = wr_cnt[g];
      d0[g] = done_cnt[g];
    end
    launch(dly, hold);
    wait_idle(2000);
    @(negedge clk);
    check("layer d0 writes", wr_cnt[0] - w0[0], 4);
    check("layer d1 writes", wr_cnt[1] - w0[1], 32);
    check("layer d0 done once", done_cnt[0] - d0[0], 1);
    check("layer d1 done once", done_cnt[1] - d0[1], 1);
    check_idle("post_layer");
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int w0[2], d0[2];
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    force_v = 1'b0;
    fixed_dly = -1;
    spur_mode = 1'b0;
    wr_cnt = '{0, 0};
    done_cnt = '{0, 0};
    #1;
    check_idle("in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    check("after_reset error", {err_s[0], err_s[1]}, 0);

    // Spurious valid in IDLE.
    force_v = 1'b1;
    repeat (2) @(negedge clk);
    force_v = 1'b0;
    @(negedge clk);
    check("idle_valid busy", {busy_s[0], busy_s[1]}, 0);
    check("idle_valid writes", wr_cnt[0] + wr_cnt[1], 0);

    // Valid two cycles after launch; start held high while busy.
    run_layer(1, 4);
    spur_mode = 1'b1;
    run_layer(0, 1);
    spur_mode = 1'b0;
    repeat (4) run_layer(-1, 1);

    // CU never answers.
    for (int g = 0; g < 2; g++) begin
      w0[g] = wr_cnt[g];
      d0[g] = done_cnt[g];
    end
    launch(-2, 1);
    wait_idle(100);
    check("timeout d0 error", err_s[0], 1);
    check("timeout d1 error", err_s[1], 1);
    check("timeout writes", (wr_cnt[0] - w0[0]) + (wr_cnt[1] - w0[1]), 0);
    check("timeout done", (done_cnt[0] - d0[0]) + (done_cnt[1] - d0[1]), 0);
    ->ev_flush;
    repeat (4) @(negedge clk);
    check("error sticky d0", err_s[0], 1);

    // Next start clears error.
    launch(1, 1);
    check("restart clears error", {err_s[0], err_s[1]}, 0);
    wait_idle(2000);
    repeat (4) @(negedge clk);

    // Abort in WAIT together with cu_out_valid.
    for (int g = 0; g < 2; g++) begin
      w0[g] = wr_cnt[g];
      d0[g] = done_cnt[g];
    end
    launch(-2, 1);
    @(negedge clk);
    abort = 1'b1;
    force_v = 1'b1;
    ->ev_flush;
    @(negedge clk);
    abort = 1'b0;
    force_v = 1'b0;
    check_idle("abort");
    check("abort writes", (wr_cnt[0] - w0[0]) + (wr_cnt[1] - w0[1]), 0);
    check("abort done", (done_cnt[0] - d0[0]) + (done_cnt[1] - d0[1]), 0);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-layer.
    launch(1, 1);
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    ->ev_flush;
    #1;
    check_idle("mid_reset");
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_layer(-1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
